// File: rtl/wb_collect_4w.sv
// Four-lane write-back collector: squashes same-address lanes within a group,
// queues groups in a small FIFO and replays them onto four register-file write ports.
module wb_collect_4w #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              in_vld,
  input  logic [4*ADDR_WIDTH-1:0] in_addr,
  input  logic [4*DATA_WIDTH-1:0] in_data,
  output logic                    in_ready,
  input  logic                    wb_en,
  output logic                    we1,
  output logic                    we2,
  output logic                    we3,
  output logic                    we4,
  output logic [ADDR_WIDTH-1:0]   waddr1,
  output logic [ADDR_WIDTH-1:0]   waddr2,
  output logic [ADDR_WIDTH-1:0]   waddr3,
  output logic [ADDR_WIDTH-1:0]   waddr4,
  output logic [DATA_WIDTH-1:0]   wdata1,
  output logic [DATA_WIDTH-1:0]   wdata2,
  output logic [DATA_WIDTH-1:0]   wdata3,
  output logic [DATA_WIDTH-1:0]   wdata4,
  output logic [$clog2(DEPTH):0]  occ,
  output logic [7:0]              drop_cnt
);

  localparam int             PW   = $clog2(DEPTH);
  localparam logic [PW:0]    FULL = (PW+1)'(DEPTH);

  logic [3:0]              mask_mem [DEPTH];
  logic [4*ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [4*DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [3:0]              squash;
  logic [3:0]              keep;
  logic [1:0]              n_drop;
  logic [8:0]              drop_sum;
  logic                    push;
  logic                    pop;

  logic [3:0]              we_q;
  logic [4*ADDR_WIDTH-1:0] waddr_q;
  logic [4*DATA_WIDTH-1:0] wdata_q;

  // A lane loses to any younger (higher-numbered) valid lane with the same address.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    squash = '0;
    for (int j = 0; j < 3; j++) begin
      for (int k = j + 1; k < 4; k++) begin
        if (in_vld[j] && in_vld[k] &&
            in_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == in_addr[k*ADDR_WIDTH +: ADDR_WIDTH])
          squash[j] = 1'b1;
      end
    end
  end

  assign keep     = in_vld & ~squash;
  assign n_drop   = {1'b0, squash[0]} + {1'b0, squash[1]} + {1'b0, squash[2]};
  assign drop_sum = {1'b0, drop_cnt} + {7'b0, n_drop};

  // Ready depends on occupancy only, so a full FIFO refuses a push even while popping.
  assign in_ready = (occ < FULL);
  assign push     = (|in_vld) && in_ready;
  assign pop      = (occ != '0) && wb_en;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; occ and the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mask_mem[wr_ptr] <= keep;
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

  // Push and pop never touch the same slot: equal pointers mean empty or full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (pop) begin
      we_q    <= mask_mem[rd_ptr];
      waddr_q <= addr_mem[rd_ptr];
      wdata_q <= data_mem[rd_ptr];
    end else begin
      we_q    <= '0;
    end
  end

  assign we1    = we_q[0];
  assign we2    = we_q[1];
  assign we3    = we_q[2];
  assign we4    = we_q[3];
  assign waddr1 = waddr_q[0*ADDR_WIDTH +: ADDR_WIDTH];
  assign waddr2 = waddr_q[1*ADDR_WIDTH +: ADDR_WIDTH];
  assign waddr3 = waddr_q[2*ADDR_WIDTH +: ADDR_WIDTH];
  assign waddr4 = waddr_q[3*ADDR_WIDTH +: ADDR_WIDTH];
  assign wdata1 = wdata_q[0*DATA_WIDTH +: DATA_WIDTH];
  assign wdata2 = wdata_q[1*DATA_WIDTH +: DATA_WIDTH];
  assign wdata3 = wdata_q[2*DATA_WIDTH +: DATA_WIDTH];
  assign wdata4 = wdata_q[3*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: tb/tb_wb_collect_4w.sv
// Self-checking bench for wb_collect_4w: vector table, corner-case sequences and a
// random run, all scored against a FIFO-of-groups scoreboard.
module tb_wb_collect_4w;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [3:0]      in_vld = '0;
  logic [4*AW-1:0] in_addr = '0;
  logic [4*DW-1:0] in_data = '0;
  logic            in_ready;
  logic            wb_en = 1'b0;
  logic            we1, we2, we3, we4;
  logic [AW-1:0]   waddr1, waddr2, waddr3, waddr4;
  logic [DW-1:0]   wdata1, wdata2, wdata3, wdata4;
  logic [OW-1:0]   occ;
  logic [7:0]      drop_cnt;

  always #5 clk = ~clk;

  wb_collect_4w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
    .wb_en(wb_en),
    .we1(we1), .we2(we2), .we3(we3), .we4(we4),
    .waddr1(waddr1), .waddr2(waddr2), .waddr3(waddr3), .waddr4(waddr4),
    .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3), .wdata4(wdata4),
    .occ(occ), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [3:0]      mask;
    logic [4*AW-1:0] addr;
    logic [4*DW-1:0] data;
  } grp_t;

  typedef struct {
    logic [3:0]      vld;
    logic [4*AW-1:0] addr;
    logic [4*DW-1:0] data;
    logic [3:0]      exp_mask;
    int              exp_drops;
  } vec_t;

  grp_t            sb[$];
  int              n_checks = 0;
  int              n_err    = 0;
  int              m_drop   = 0;
  logic [4*AW-1:0] last_addr = '0;
  logic [4*DW-1:0] last_data = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [4*DW-1:0] mk_data(input logic [DW-1:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  // Independent squash model: walk from the youngest lane down, claiming addresses.
  function automatic logic [3:0] model_keep(input logic [3:0] vld, input logic [4*AW-1:0] a);
    logic [31:0] claimed;
    logic [3:0]  keep;
    claimed = '0;
    keep    = '0;
    for (int j = 3; j >= 0; j--) begin
      if (vld[j]) begin
        if (!claimed[a[j*AW +: AW]]) keep[j] = 1'b1;
        claimed[a[j*AW +: AW]] = 1'b1;
      end
    end
    return keep;
  endfunction

  // One clock: drive at edge+1, check ready, then check registered outputs at next edge+1.
  task automatic step(input logic [3:0] vld, input logic [4*AW-1:0] a, input logic [4*DW-1:0] d,
                      input logic en, input logic [3:0] emask, input int edrops);
    grp_t g;
    bit   acc;
    bit   pops;
    g      = '{4'b0, '0, '0};
    in_vld  = vld;
    in_addr = a;
    in_data = d;
    wb_en   = en;
    #1;
    check("in_ready", 128'(in_ready), 128'(sb.size() < DEPTH));
    acc  = (vld != 4'b0) && (sb.size() < DEPTH);
    pops = (sb.size() != 0) && en;
    @(posedge clk);
    if (pops) begin
      g         = sb.pop_front();
      last_addr = g.addr;
      last_data = g.data;
    end
    if (acc) begin
      sb.push_back('{emask, a, d});
      m_drop = (m_drop + edrops > 255) ? 255 : m_drop + edrops;
    end
    #1;
    check("we",       128'({we4, we3, we2, we1}), 128'(pops ? g.mask : 4'b0000));
    check("waddr",    128'({waddr4, waddr3, waddr2, waddr1}), 128'(last_addr));
    check("wdata",    128'({wdata4, wdata3, wdata2, wdata1}), 128'(last_data));
    check("occ",      128'(occ), 128'(sb.size()));
    check("drop_cnt", 128'(drop_cnt), 128'(m_drop));
  endtask

  task automatic step_m(input logic [3:0] vld, input logic [4*AW-1:0] a,
                        input logic [4*DW-1:0] d, input logic en);
    logic [3:0] k;
    k = model_keep(vld, a);
    step(vld, a, d, en, k, $countones(vld) - $countones(k));
  endtask

  task automatic idle(input logic en);
    step(4'b0000, '0, '0, en, 4'b0000, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_we"},       128'({we4, we3, we2, we1}), 128'(4'b0000));
    check({tag, "_occ"},      128'(occ), 128'(0));
    check({tag, "_drop"},     128'(drop_cnt), 128'(0));
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    check({tag, "_waddr"},    128'({waddr4, waddr3, waddr2, waddr1}), 128'(0));
    check({tag, "_wdata"},    128'({wdata4, wdata3, wdata2, wdata1}), 128'(0));
  endtask

  vec_t vt[9];

  initial begin
    // Addresses listed lane3..lane0.
    vt[0] = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h0, 32'hAA}, 4'b0001, 0};
    vt[1] = '{4'b1111, {5'd5, 5'd5, 5'd7, 5'd5}, mk_data(32'h1000), 4'b1010, 2};
    vt[2] = '{4'b0000, {5'd1, 5'd2, 5'd3, 5'd4}, mk_data(32'h2000), 4'b0000, 0};
    vt[3] = '{4'b1010, {5'd9, 5'd1, 5'd9, 5'd2}, mk_data(32'h3000), 4'b1000, 1};
    vt[4] = '{4'b0101, {5'd4, 5'd6, 5'd4, 5'd4}, mk_data(32'h4000), 4'b0101, 0};
    vt[5] = '{4'b1111, {5'd1, 5'd2, 5'd3, 5'd4}, mk_data(32'h5000), 4'b1111, 0};
    vt[6] = '{4'b1111, {5'd31, 5'd31, 5'd31, 5'd31}, mk_data(32'h6000), 4'b1000, 3};
    vt[7] = '{4'b0111, {5'd8, 5'd8, 5'd6, 5'd8}, mk_data(32'h7000), 4'b0110, 1};
    vt[8] = '{4'b1001, {5'd0, 5'd3, 5'd3, 5'd0}, mk_data(32'h8000), 4'b1000, 1};

    #3;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors: push each group, then an idle cycle that drains it.
    for (int i = 0; i < 9; i++) begin
      step(vt[i].vld, vt[i].addr, vt[i].data, 1'b1, vt[i].exp_mask, vt[i].exp_drops);
      idle(1'b1);
    end

    // Backpressure: fill with wb_en low, overflow attempts, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      step(4'b1111, {5'(4*i+3), 5'(4*i+2), 5'(4*i+1), 5'(4*i)}, mk_data(32'h100 * i), 1'b0, 4'b1111, 0);
    step(4'b1111, {5'd20, 5'd21, 5'd22, 5'd23}, mk_data(32'hDEAD0), 1'b0, 4'b1111, 0);
    step(4'b1111, {5'd24, 5'd25, 5'd26, 5'd27}, mk_data(32'hBEEF0), 1'b1, 4'b1111, 0);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

    // Simultaneous push and pop at occ=2.
    step_m(4'b0011, {5'd0, 5'd0, 5'd2, 5'd1}, mk_data(32'hA00), 1'b0);
    step_m(4'b1100, {5'd4, 5'd3, 5'd0, 5'd0}, mk_data(32'hB00), 1'b0);
    step_m(4'b1111, {5'd6, 5'd6, 5'd6, 5'd5}, mk_data(32'hC00), 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Drop counter saturation: 90 groups of four equal addresses.
    for (int i = 0; i < 90; i++)
      step(4'b1111, {4{5'(i % 32)}}, mk_data(32'(i) << 8), 1'b1, 4'b1000, 3);
    idle(1'b1);

    // Reset mid-stream with occ=3 and a write on the ports.
    for (int i = 0; i < 3; i++)
      step_m(4'b0001 << i, {4{5'(10 + i)}}, mk_data(32'hE00 + 32'(i)), 1'b0);
    step_m(4'b1000, {5'd13, 5'd0, 5'd0, 5'd0}, mk_data(32'hF00), 1'b1);
    #2;
    rst    = 1'b0;
    in_vld = 4'b0000;
    #1;
    check_reset_state("midreset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    m_drop    = 0;
    last_addr = '0;
    last_data = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) idle(1'b1);
    step(vt[1].vld, vt[1].addr, vt[1].data, 1'b1, vt[1].exp_mask, vt[1].exp_drops);
    idle(1'b1);

    // Random traffic with narrow addresses to provoke conflicts.
    for (int n = 0; n < 200; n++) begin
      logic [4*AW-1:0] a;
      logic [4*DW-1:0] d;
      for (int l = 0; l < 4; l++) begin
        a[l*AW +: AW] = AW'($urandom_range(0, 3));
        d[l*DW +: DW] = $urandom;
      end
      step_m(4'($urandom), a, d, 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
